// File: rtl/skolem_ic_sweep_checker.sv
// Exhaustive sweep checker for a combinational Skolem-function netlist that
// answers the bvlshr invertibility condition ((t << s) >> s) == t.
// Every {t,s} vector is driven for one settle cycle and sampled in the next.
// Each answer is compared against an internal golden predicate. The checker
// reports pass/fail, a saturating mismatch count and the first failing vector.
// Optional feature macro: SKOLEM_SWEEP_STOP_ON_FAIL_EN (end the sweep on the
// first mismatch).
module skolem_ic_sweep_checker #(
  parameter int W     = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [2*W-1:0]    skolem_in,
  input  logic              skolem_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [2*W-1:0]    first_fail_vec,
  output logic              first_fail_vld
);

  localparam int IN_W = 2 * W;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE_S
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IN_W-1:0]  vec;
  logic [W-1:0]     t_op;
  logic [W-1:0]     s_op;
  logic [W-1:0]     shl;
  logic             golden;
  logic             mismatch;
  logic             last_vec;
  logic [CNT_W-1:0] cnt_next;

  // Golden invertibility predicate and the mismatch count after this sample.
  always_comb begin
    t_op     = vec[IN_W-1:W];
    s_op     = vec[W-1:0];
    // A shift amount of W or more empties the W-bit result, so golden falls
    // back to (t == 0) without a separate case.
    shl      = t_op << s_op;
    golden   = ((shl >> s_op) == t_op);
    mismatch = (skolem_out != golden);
    last_vec = (vec == {IN_W{1'b1}});
    cnt_next = mismatch_cnt;
    if (mismatch && (mismatch_cnt != {CNT_W{1'b1}})) begin
      cnt_next = mismatch_cnt + 1'b1;
    end
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    state_next = state;
    busy       = (state != IDLE);
    done       = (state == DONE_S);
    case (state)
      IDLE:   if (start) state_next = DRIVE;
      DRIVE:  state_next = SAMPLE;
      SAMPLE: begin
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
        if (last_vec || mismatch) state_next = DONE_S;
        else                      state_next = DRIVE;
`else
        if (last_vec) state_next = DONE_S;
        else          state_next = DRIVE;
`endif
      end
      DONE_S: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, vector counter and result registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      state          <= IDLE;
      vec            <= '0;
      skolem_in      <= '0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      first_fail_vec <= '0;
      first_fail_vld <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            vec            <= '0;
            mismatch_cnt   <= '0;
            first_fail_vec <= '0;
            first_fail_vld <= 1'b0;
            pass           <= 1'b0;
          end
        end
        DRIVE: begin
          skolem_in <= vec;
        end
        SAMPLE: begin
          mismatch_cnt <= cnt_next;
          if (mismatch && !first_fail_vld) begin
            first_fail_vec <= vec;
            first_fail_vld <= 1'b1;
          end
          // Result is settled as the sweep ends so pass is valid alongside done.
          if (state_next == DONE_S) begin
            pass <= (cnt_next == '0);
          end else begin
            vec <= vec + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_ic_sweep_checker.sv
// Directed bench for skolem_ic_sweep_checker (W=4). A behavioural netlist
// model answers the checker in several modes: correct, tied 0, tied 1, or
// correct apart from one wrong vector. A second instance with CNT_W=4 exercises
// counter saturation. Expectations follow SKOLEM_SWEEP_STOP_ON_FAIL_EN.
module tb_skolem_ic_sweep_checker;

  localparam int W    = 4;
  localparam int IN_W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [IN_W-1:0] skolem_in;
  logic            skolem_out;
  logic            busy, done, pass;
  logic [15:0]     mismatch_cnt;
  logic [IN_W-1:0] first_fail_vec;
  logic            first_fail_vld;

  logic            start_s;
  logic [IN_W-1:0] skolem_in_s;
  logic            busy_s, done_s, pass_s;
  logic [3:0]      mismatch_cnt_s;
  logic [IN_W-1:0] first_fail_vec_s;
  logic            first_fail_vld_s;

  int              mode;     // 0 correct, 1 tied 0, 2 tied 1, 3 one bad vector
  logic [IN_W-1:0] err_vec;
  int              n_cmp = 0;
  int              n_err = 0;

  always #5 clk = ~clk;

  skolem_ic_sweep_checker #(.W(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .skolem_in(skolem_in),
    .skolem_out(skolem_out), .busy(busy), .done(done), .pass(pass),
    .mismatch_cnt(mismatch_cnt), .first_fail_vec(first_fail_vec),
    .first_fail_vld(first_fail_vld)
  );

  // Narrow-counter instance; its netlist is permanently tied to 1.
  skolem_ic_sweep_checker #(.W(W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .start(start_s), .skolem_in(skolem_in_s),
    .skolem_out(1'b1), .busy(busy_s), .done(done_s), .pass(pass_s),
    .mismatch_cnt(mismatch_cnt_s), .first_fail_vec(first_fail_vec_s),
    .first_fail_vld(first_fail_vld_s)
  );

  // Reference IC: shifting left by s keeps t intact iff the top s bits of t
  // are zero; s >= W leaves nothing, so only t == 0 survives.
  function automatic logic ref_ic(input logic [IN_W-1:0] v);
    logic [3:0] t, s;
    t = v[7:4];
    s = v[3:0];
    if (s >= 4'd4) return (t == 4'd0);
    return ((t >> (3'd4 - s[2:0])) == 4'd0);
  endfunction

  // Behavioural netlist driven by the checker's skolem_in.
  always_comb begin
    case (mode)
      1:       skolem_out = 1'b0;
      2:       skolem_out = 1'b1;
      3:       skolem_out = ref_ic(skolem_in) ^ (skolem_in == err_vec);
      default: skolem_out = ref_ic(skolem_in);
    endcase
  end

  // Pulse start, then count cycles after the start edge until done (0 = timeout).
  task automatic run_sweep(output int done_cyc, output logic busy_c1);
    int cyc;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    busy_c1  = busy;
    done_cyc = 0;
    cyc      = 1;
    while (cyc < 2000) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic cmp(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; start_s = 1'b0; mode = 0; err_vec = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (skolem_in !== 8'h00) begin n_err++; $display("FAIL reset_skolem_in: got %0h expected 0", skolem_in); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b expected 0", done); end
    n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL reset_pass: got %0b expected 0", pass); end
    n_cmp++; if (mismatch_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt: got %0h expected 0", mismatch_cnt); end
    n_cmp++; if (first_fail_vec !== 8'h00) begin n_err++; $display("FAIL reset_ffvec: got %0h expected 0", first_fail_vec); end
    n_cmp++; if (first_fail_vld !== 1'b0) begin n_err++; $display("FAIL reset_ffvld: got %0b expected 0", first_fail_vld); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_golden_sweep();
    int dc; logic b1;
    mode = 0;
    run_sweep(dc, b1);
    n_cmp++; if (b1 !== 1'b1) begin n_err++; $display("FAIL golden_busy_c1: got %0b expected 1", b1); end
    n_cmp++; if (dc != 513) begin n_err++; $display("FAIL golden_done_cycle: got %0d expected 513", dc); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL golden_busy_at_done: got %0b expected 1", busy); end
    n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL golden_pass: got %0b expected 1", pass); end
    n_cmp++; if (mismatch_cnt !== 16'd0) begin n_err++; $display("FAIL golden_cnt: got %0d expected 0", mismatch_cnt); end
    n_cmp++; if (first_fail_vld !== 1'b0) begin n_err++; $display("FAIL golden_ffvld: got %0b expected 0", first_fail_vld); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL golden_done_width: got %0b expected 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL golden_busy_after: got %0b expected 0", busy); end
    n_cmp++; if (skolem_in !== 8'hFF) begin n_err++; $display("FAIL golden_hold_in: got %0h expected ff", skolem_in); end
  endtask

  task automatic test_tied_zero();
    int dc; logic b1; int exp_dc; int exp_cnt;
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
    exp_dc = 3;   exp_cnt = 1;
`else
    exp_dc = 513; exp_cnt = 42;
`endif
    mode = 1;
    run_sweep(dc, b1);
    n_cmp++; if (dc != exp_dc) begin n_err++; $display("FAIL tie0_done_cycle: got %0d expected %0d", dc, exp_dc); end
    n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL tie0_pass: got %0b expected 0", pass); end
    n_cmp++; if (mismatch_cnt != 16'(exp_cnt)) begin n_err++; $display("FAIL tie0_cnt: got %0d expected %0d", mismatch_cnt, exp_cnt); end
    n_cmp++; if (first_fail_vec !== 8'h00) begin n_err++; $display("FAIL tie0_ffvec: got %0h expected 00", first_fail_vec); end
    n_cmp++; if (first_fail_vld !== 1'b1) begin n_err++; $display("FAIL tie0_ffvld: got %0b expected 1", first_fail_vld); end
    @(posedge clk); #1;
  endtask

  task automatic test_tied_one();
    int dc; logic b1; int exp_dc; int exp_cnt;
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
    exp_dc = 43;  exp_cnt = 1;
`else
    exp_dc = 513; exp_cnt = 214;
`endif
    mode = 2;
    run_sweep(dc, b1);
    n_cmp++; if (dc != exp_dc) begin n_err++; $display("FAIL tie1_done_cycle: got %0d expected %0d", dc, exp_dc); end
    n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL tie1_pass: got %0b expected 0", pass); end
    n_cmp++; if (mismatch_cnt != 16'(exp_cnt)) begin n_err++; $display("FAIL tie1_cnt: got %0d expected %0d", mismatch_cnt, exp_cnt); end
    n_cmp++; if (first_fail_vec !== 8'h14) begin n_err++; $display("FAIL tie1_ffvec: got %0h expected 14", first_fail_vec); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_error();
    int dc; logic b1; int exp_dc;
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
    exp_dc = 183;
`else
    exp_dc = 513;
`endif
    mode = 3; err_vec = 8'h5A;
    run_sweep(dc, b1);
    n_cmp++; if (dc != exp_dc) begin n_err++; $display("FAIL single_done_cycle: got %0d expected %0d", dc, exp_dc); end
    n_cmp++; if (mismatch_cnt !== 16'd1) begin n_err++; $display("FAIL single_cnt: got %0d expected 1", mismatch_cnt); end
    n_cmp++; if (first_fail_vec !== 8'h5A) begin n_err++; $display("FAIL single_ffvec: got %0h expected 5a", first_fail_vec); end
    n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL single_pass: got %0b expected 0", pass); end
    @(posedge clk); #1;
  endtask

  // Starts while busy and in the DONE cycle must not restart or disturb results.
  task automatic test_start_ignored();
    int cyc; int dc; int exp_dc; int exp_cnt;
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
    exp_dc = 43;  exp_cnt = 1;
`else
    exp_dc = 513; exp_cnt = 214;
`endif
    mode = 2;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 1; dc = 0;
    while (cyc < 2000) begin
      if (done) begin dc = cyc; break; end
      start = (cyc == 20);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    n_cmp++; if (dc != exp_dc) begin n_err++; $display("FAIL ign_done_cycle: got %0d expected %0d", dc, exp_dc); end
    start = 1'b1;               // sampled on the edge that ends the DONE cycle
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_done_start_busy: got %0b expected 0", busy); end
    repeat (10) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ign_idle_busy: got %0b expected 0", busy); end
    n_cmp++; if (mismatch_cnt != 16'(exp_cnt)) begin n_err++; $display("FAIL ign_cnt_hold: got %0d expected %0d", mismatch_cnt, exp_cnt); end
    n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL ign_pass_hold: got %0b expected 0", pass); end
  endtask

  task automatic test_saturation();
    int cyc; int dc; logic [3:0] exp_cnt;
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
    exp_cnt = 4'h1;
`else
    exp_cnt = 4'hF;
`endif
    @(negedge clk); start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0;
    cyc = 1; dc = 0;
    while (cyc < 2000) begin
      if (done_s) begin dc = cyc; break; end
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++; if (dc == 0) begin n_err++; $display("FAIL sat_done_seen: got timeout expected done"); end
    n_cmp++; if (mismatch_cnt_s !== exp_cnt) begin n_err++; $display("FAIL sat_cnt: got %0h expected %0h", mismatch_cnt_s, exp_cnt); end
    n_cmp++; if (pass_s !== 1'b0) begin n_err++; $display("FAIL sat_pass: got %0b expected 0", pass_s); end
    n_cmp++; if (first_fail_vec_s !== 8'h14) begin n_err++; $display("FAIL sat_ffvec: got %0h expected 14", first_fail_vec_s); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_sweep();
    int cyc; logic saw_done; int dc; logic b1;
`ifdef SKOLEM_SWEEP_STOP_ON_FAIL_EN
    mode = 0;
`else
    mode = 2;
`endif
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 1;
    while (cyc < 100) begin @(posedge clk); #1; cyc++; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %0b expected 0", busy); end
    n_cmp++; if (skolem_in !== 8'h00) begin n_err++; $display("FAIL rstmid_skolem_in: got %0h expected 0", skolem_in); end
    n_cmp++; if (mismatch_cnt !== 16'd0) begin n_err++; $display("FAIL rstmid_cnt: got %0d expected 0", mismatch_cnt); end
    n_cmp++; if (first_fail_vld !== 1'b0 || first_fail_vec !== 8'h00) begin n_err++; $display("FAIL rstmid_ff: got %0b/%0h expected 0/0", first_fail_vld, first_fail_vec); end
    n_cmp++; if (pass !== 1'b0) begin n_err++; $display("FAIL rstmid_pass: got %0b expected 0", pass); end
    saw_done = 1'b0;
    repeat (8) begin
      if (done || busy) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL rstmid_no_done: got %0b expected 0", saw_done); end
    mode = 0;
    run_sweep(dc, b1);
    n_cmp++; if (dc != 513) begin n_err++; $display("FAIL rstmid_restart_cycle: got %0d expected 513", dc); end
    n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL rstmid_restart_pass: got %0b expected 1", pass); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_golden_sweep();
    test_tied_zero();
    test_tied_one();
    test_single_error();
    test_start_ignored();
    test_saturation();
    test_golden_sweep();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
